spi_sram_responder: RTL
=======================

Name: spi_sram_responder

Overview:
- SPI slave that emulates one serial SRAM (23LC1024-style command set) inside the FPGA.
- It is the target end of the SRAM SPI link: it answers the same traffic the FPGA-side SPI master and the Raspberry Pi send to an external SRAM channel.
- Used as an on-chip stand-in for a missing or bad SRAM chip, and as the responder model in loop-back tests of the SRAM channel path.
- Backing store is an internal byte array; SPI pins are oversampled on the system clock.

Parameters:
- DEPTH, 4096: bytes of backing store; must be a power of two.
- ADDR_W, 12: log2(DEPTH); the low ADDR_W bits of the 24-bit SPI address select the byte.

Ports:
- clk  input  1  system clock; must be at least 4x the SPI clock frequency.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from the master, mode 0.
- chip_enable  input  1  active-low chip select.
- mosi  input  1  serial data from master, MSB first.
- miso  output  1  serial data to master; 0 when not driving.
- miso_oe  output  1  high while in a read data phase.
- wr_strobe  output  1  one-clk pulse when a byte is committed to the array.
- xfer_done  output  1  one-clk pulse when chip_enable rises after a recognised command.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Input synchronisation:
  - sclk, chip_enable and mosi each pass through a 2-flop synchroniser.
  - Rise and fall of sync_sclk are detected with a third flop.
  - All shifting is done in the clk domain.
- Reset values: every output is 0; state is IDLE; shift and bit counters are 0. Array contents are not cleared, either by reset or by any other event.
- States: IDLE, INST, ADDR, WRITE, READ, IGNORE.
- Transitions:
  - IDLE -> INST on chip_enable going low. bit_cnt is cleared.
  - INST: samples mosi on each sclk rise. After 8 bits:
    - 0x03 -> ADDR, read flag set.
    - 0x02 -> ADDR, write flag set.
    - any other value -> IGNORE.
  - ADDR: samples 24 bits, MSB first. The address register keeps the low ADDR_W bits. After bit 24, go to READ or WRITE according to the flag.
  - WRITE:
    - Every 8 sampled bits, write the byte to mem[addr], pulse wr_strobe, and set addr <= addr+1 modulo DEPTH (wraps DEPTH-1 -> 0).
  - READ:
    - On the rise that completes bit 24 of the address, mem[addr] is loaded into tx_shift within 1 clk, and addr is incremented.
    - On each sclk fall, miso <= tx_shift[7] and tx_shift shifts left.
    - After the 8th fall of each byte, the next byte mem[addr] is preloaded and addr increments (modulo DEPTH). This gives a continuous sequential read.
    - miso_oe = 1 throughout READ.
  - IGNORE: miso stays 0; all sclk edges are ignored.
  - Any state -> IDLE on chip_enable going high.
    - xfer_done pulses only if the state was WRITE or READ.
    - A partial write byte is discarded. miso and miso_oe drop to 0 in the same clk.
- Latency: miso changes within 3 clk of the external sclk fall (2 sync + 1 register).
- Edge-case rules:
  - An sclk edge in the same synchronised cycle as the chip_enable rise is ignored.
  - Reset mid-transfer returns to IDLE immediately. A byte that was not yet committed is not written.
  - Back-to-back transactions with a one-cycle chip_enable-high gap (after synchronisation) are accepted.
- The array is inferred as synchronous-read RAM: one write port and one read port, each used at most once per clk.

Optional Feature:
- Macro: SPI_SRAM_MODE_REG_EN.
- When defined, an 8-bit mode register is added, reset to 0x40 (sequential mode).
  - 0x01 (WRMR) takes the next byte into the register.
  - 0x05 (RDMR) shifts the register out on miso, repeating while chip_enable stays low.
  - Mode bits [7:6]:
    - 00 = byte mode: after one data byte, go to IGNORE.
    - 10 = page mode: addr wraps within 32-byte pages.
    - 01 = sequential mode.
    - 11 = treated as sequential.
- When not defined, 0x01 and 0x05 go to IGNORE, and behaviour is always sequential.

Decomposition:
- Package spi_sram_pkg holds:
  - state_t enum;
  - INST_READ=8'h03, INST_WRITE=8'h02, INST_RDMR=8'h05, INST_WRMR=8'h01;
  - MODE_BYTE, MODE_PAGE, MODE_SEQ;
  - ADDR_BITS=24.
- One sub-module: spi_edge_sync. It holds the synchroniser and edge detect, and outputs sclk_rise, sclk_fall, cs_n_sync, mosi_sync.

Test Plan:
- Write 0x02, addr 0x000010, data 0xA5 0x5A, then chip_enable high -> two wr_strobe pulses; mem[0x10]=0xA5, mem[0x11]=0x5A; one xfer_done pulse.
- Read 0x03, addr 0x000010, 16 sclk -> miso bytes 0xA5 then 0x5A; miso_oe high only during the data phase.
- Write at addr 0x000FFF with data 0x11 0x22 -> mem[0xFFF]=0x11, mem[0x000]=0x22 (wrap-around). A read from 0xFFF returns 0x11 then 0x22.
- Instruction 0x9F followed by 32 clocks -> no wr_strobe; miso=0 and miso_oe=0 throughout; busy drops when chip_enable goes high; no xfer_done.
- Write 0x02, addr 0x20, 0xFF, then only 4 more bits before chip_enable goes high -> mem[0x20]=0xFF, mem[0x21] unchanged. Assert reset mid-address in a second transaction -> all outputs 0 and state IDLE within 1 clk.
- With SPI_SRAM_MODE_REG_EN defined: WRMR with 0x00, then read 2 bytes from 0x10 -> first byte 0xA5, second byte's miso all 0; RDMR returns 0x00.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI serial-SRAM responder.
package spi_sram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INST,
      ADDR,
      WRITE,
      READ,
      IGNORE
   } state_t;

   localparam logic [7:0] INST_READ  = 8'h03;
   localparam logic [7:0] INST_WRITE = 8'h02;
   localparam logic [7:0] INST_RDMR  = 8'h05;
   localparam logic [7:0] INST_WRMR  = 8'h01;

   // Mode register bits [7:6]; 2'b11 behaves as sequential
   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_PAGE = 2'b10;
   localparam logic [1:0] MODE_SEQ  = 2'b01;
   localparam logic [7:0] MODE_RST  = {MODE_SEQ, 6'b0};

   localparam int unsigned ADDR_BITS = 24;
   localparam int unsigned PAGE_W    = 5;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for the SPI pins plus sclk rise/fall detection.
module spi_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic chip_enable,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_n_sync,
   output logic mosi_sync
);

   logic [1:0] r_sclk_ff;
   logic [1:0] r_cs_ff;
   logic [1:0] r_mosi_ff;
   logic       r_sclk_d;

   // Chip select resets to the deselected level so reset release is not a select
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sclk_ff <= '0;
         r_cs_ff   <= '1;
         r_mosi_ff <= '0;
         r_sclk_d  <= 1'b0;
      end else begin
         r_sclk_ff <= {r_sclk_ff[0], sclk};
         r_cs_ff   <= {r_cs_ff[0], chip_enable};
         r_mosi_ff <= {r_mosi_ff[0], mosi};
         r_sclk_d  <= r_sclk_ff[1];
      end
   end

   assign sclk_rise = r_sclk_ff[1] & ~r_sclk_d;
   assign sclk_fall = ~r_sclk_ff[1] & r_sclk_d;
   assign cs_n_sync = r_cs_ff[1];
   assign mosi_sync = r_mosi_ff[1];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave emulating a 23LC1024-style serial SRAM backed by an internal byte array.
// Define SPI_SRAM_MODE_REG_EN to add the WRMR/RDMR mode register (byte/page/sequential).
module spi_sram_responder
   import spi_sram_pkg::*;
#(
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned ADDR_W = 12
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic chip_enable,
   input  logic mosi,
   output logic miso,
   output logic miso_oe,
   output logic wr_strobe,
   output logic xfer_done,
   output logic busy
);

   localparam logic [4:0] LAST_ADDR_BIT = 5'(ADDR_BITS - 1);

   logic              w_sclk_rise;
   logic              w_sclk_fall;
   logic              w_cs_n;
   logic              w_mosi;

   state_t            r_state;
   state_t            w_state_next;
   logic [4:0]        r_bit_cnt;
   logic [6:0]        r_rx_shift;
   logic [7:0]        r_tx_shift;
   logic [ADDR_W-1:0] r_addr;
   logic              r_is_read;
   logic              r_load;
   logic              r_byte_done;
   logic              r_miso;
   logic              r_wr_strobe;
   logic              r_xfer_done;

   logic [7:0]        r_mem [DEPTH];
   logic [7:0]        r_rd_data;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_mem_we;
   logic              w_done;

   logic [7:0]        w_rx_byte;
   logic [ADDR_W-1:0] w_addr_shift;
   logic [ADDR_W-1:0] w_addr_inc;

   logic [7:0]        w_mode_val;
   logic              w_mode_op;
   logic              w_byte_mode;
   logic              w_page_mode;

   spi_edge_sync u_sync (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .chip_enable (chip_enable),
      .mosi        (mosi),
      .sclk_rise   (w_sclk_rise),
      .sclk_fall   (w_sclk_fall),
      .cs_n_sync   (w_cs_n),
      .mosi_sync   (w_mosi)
   );

`ifdef SPI_SRAM_MODE_REG_EN
   localparam bit MODE_EN = 1'b1;

   logic [7:0] r_mode;
   logic       r_mode_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode    <= MODE_RST;
         r_mode_op <= 1'b0;
      end else if (!w_cs_n && w_sclk_rise && r_bit_cnt == 5'd7) begin
         if (r_state == INST)
            r_mode_op <= (w_rx_byte == INST_RDMR) || (w_rx_byte == INST_WRMR);
         if (r_state == WRITE && r_mode_op)
            r_mode <= w_rx_byte;
      end
   end

   assign w_mode_val  = r_mode;
   assign w_mode_op   = r_mode_op;
   assign w_byte_mode = (r_mode[7:6] == MODE_BYTE);
   assign w_page_mode = (r_mode[7:6] == MODE_PAGE);
`else
   localparam bit MODE_EN = 1'b0;

   assign w_mode_val  = '0;
   assign w_mode_op   = 1'b0;
   assign w_byte_mode = 1'b0;
   assign w_page_mode = 1'b0;
`endif

   assign w_rx_byte    = {r_rx_shift, w_mosi};
   assign w_addr_shift = {r_addr[ADDR_W-2:0], w_mosi};
   assign w_addr_inc   = w_page_mode
                         ? {r_addr[ADDR_W-1:PAGE_W], r_addr[PAGE_W-1:0] + PAGE_W'(1)}
                         : r_addr + ADDR_W'(1);

   always_comb begin
      w_state_next = r_state;
      w_mem_we     = 1'b0;
      w_done       = 1'b0;
      w_rd_addr    = r_addr;
      // Deselect wins over any sclk edge seen in the same cycle
      if (w_cs_n) begin
         w_state_next = IDLE;
         w_done       = (r_state == WRITE) || (r_state == READ);
      end else begin
         case (r_state)
            IDLE: w_state_next = INST;
            INST: begin
               if (w_sclk_rise && r_bit_cnt == 5'd7) begin
                  if (w_rx_byte == INST_READ || w_rx_byte == INST_WRITE)
                     w_state_next = ADDR;
                  else if (MODE_EN && w_rx_byte == INST_RDMR)
                     w_state_next = READ;
                  else if (MODE_EN && w_rx_byte == INST_WRMR)
                     w_state_next = WRITE;
                  else
                     w_state_next = IGNORE;
               end
            end
            ADDR: begin
               if (w_sclk_rise && r_bit_cnt == LAST_ADDR_BIT) begin
                  w_state_next = r_is_read ? READ : WRITE;
                  w_rd_addr    = w_addr_shift;
               end
            end
            WRITE: begin
               if (w_sclk_rise && r_bit_cnt == 5'd7) begin
                  w_mem_we = !w_mode_op;
                  if (w_mode_op || w_byte_mode)
                     w_state_next = IGNORE;
               end
            end
            READ: begin
               if (w_sclk_fall && r_byte_done)
                  w_state_next = IGNORE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[r_addr] <= w_rx_byte;
      r_rd_data <= r_mem[w_rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_addr      <= '0;
         r_is_read   <= 1'b0;
         r_load      <= 1'b0;
         r_byte_done <= 1'b0;
         r_miso      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_xfer_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_wr_strobe <= w_mem_we;
         r_xfer_done <= w_done;
         r_load      <= 1'b0;
         if (!w_cs_n) begin
            case (r_state)
               INST: begin
                  if (w_sclk_rise) begin
                     r_rx_shift <= w_rx_byte[6:0];
                     r_bit_cnt  <= r_bit_cnt + 5'd1;
                     r_is_read  <= (w_rx_byte == INST_READ);
                     r_tx_shift <= w_mode_val;
                  end
               end
               ADDR: begin
                  if (w_sclk_rise) begin
                     r_addr    <= w_addr_shift;
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                     r_load    <= r_is_read && (r_bit_cnt == LAST_ADDR_BIT);
                  end
               end
               WRITE: begin
                  if (w_sclk_rise) begin
                     r_rx_shift <= w_rx_byte[6:0];
                     r_bit_cnt  <= r_bit_cnt + 5'd1;
                     if (r_bit_cnt == 5'd7) begin
                        r_bit_cnt <= '0;
                        if (!w_mode_op)
                           r_addr <= w_addr_inc;
                     end
                  end
               end
               READ: begin
                  // r_rd_data was addressed on the previous clk; take it and advance
                  if (r_load) begin
                     r_tx_shift <= r_rd_data;
                     r_addr     <= w_addr_inc;
                  end
                  if (w_sclk_fall) begin
                     r_miso     <= r_tx_shift[7];
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                     r_bit_cnt  <= r_bit_cnt + 5'd1;
                     if (r_bit_cnt == 5'd7) begin
                        r_bit_cnt <= '0;
                        if (w_mode_op)
                           r_tx_shift <= w_mode_val;
                        else if (w_byte_mode)
                           r_byte_done <= 1'b1;
                        else
                           r_load <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end else begin
            r_byte_done <= 1'b0;
         end
         if (w_state_next != r_state)
            r_bit_cnt <= '0;
         if (w_state_next != READ)
            r_miso <= 1'b0;
      end
   end

   assign miso      = r_miso;
   assign miso_oe   = (r_state == READ);
   assign wr_strobe = r_wr_strobe;
   assign xfer_done = r_xfer_done;
   assign busy      = (r_state != IDLE);

endmodule
